corner_stream_collector: RTL and testbench
==========================================

Name: corner_stream_collector

Overview:
- Consumer end of the corner stream produced by the FAST+NMS detector.
- Samples the detector's ce/iscorner/x/y raster stream and buffers accepted corner coordinates in a FIFO.
- Appends one end-of-frame token per frame carrying that frame's corner count.
- Presents entries to a downstream reader (DMA/UART packer) over a valid/ready interface.

Parameters:
COL_NUM, 640, image width in pixels
ROW_NUM, 480, image height in pixels
COORD_WIDTH, 10, width of each coordinate
FIFO_DEPTH, 64, entry count; power of two, >=4
DROP_WIDTH, 16, width of dropped-corner counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ce  in  1  input sample qualifier; x/y are valid raster positions on every ce cycle
iscorner  in  1  current position is a post-NMS corner (qualified by ce)
x_coord  in  COORD_WIDTH  raster column
y_coord  in  COORD_WIDTH  raster row
m_valid  out  1  output entry valid
m_ready  in  1  reader accepts the entry
m_data  out  2*COORD_WIDTH  corner entry: {y,x}; token entry: corner count, zero-extended
m_eof  out  1  1 = end-of-frame token, 0 = corner
overflow  out  1  sticky; set on any drop
clr_ovf  in  1  synchronous clear of overflow and drop_cnt
drop_cnt  out  DROP_WIDTH  dropped corners, saturating
fifo_level  out  log2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, asynchronous) empties the FIFO and clears all state: m_valid=0, m_data=0, m_eof=0, overflow=0, drop_cnt=0, fifo_level=0, frame count=0, hold register empty, token pending=0.
- Corner event: ce=1 and iscorner=1 at a clock edge. Events with ce=0 are ignored.
- Frame end: a ce=1 sample with x=COL_NUM-1 and y=ROW_NUM-1 sets token_pending at that edge.
- Write port accepts one write per cycle. Priority:
  - Token: when token_pending=1, write {eof=1, count} and clear pending. count = corners written for the frame, saturating at all-ones. Then reset the frame count to 0.
  - Held corner.
  - New corner event.
- Final-pixel corner: the corner is written at that same edge and counted in the ending frame. The token follows on the next cycle.
- Corner collides with a token write or a held-corner write: the corner enters a one-entry hold register and is written the next free cycle. It counts toward the new frame.
  - Second collision while hold is full: drop the corner.
- Space rule: a corner is written only if free entries >= 2, so one slot stays reserved for the token.
  - Otherwise drop: drop_cnt+1 (saturating) and overflow=1.
  - A token is written if free >= 1; otherwise it stays pending and retries each cycle. While a token is pending, new-frame corners go to hold or are dropped.
- Latency: a corner sampled at edge t, with FIFO empty and no collision, gives m_valid=1 with that entry after edge t+1 (one-cycle write, first-word fall-through).
- Read: entry pops at an edge where m_valid and m_ready are both 1. m_data and m_eof stay stable while m_valid=1 and m_ready=0.
- Read and write in the same cycle: both happen; level is unchanged. Read of the last entry plus write: the new entry is valid next cycle without a bubble.
- clr_ovf: clears overflow and drop_cnt. A drop in the same cycle wins: overflow=1, drop_cnt=1.
- Order preserved: no corner crosses its frame's token.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by fifo_level.

Test Plan:
- Basic corner (COL_NUM=16, ROW_NUM=8, m_ready=1): single corner at (5,7) → m_data={7,5}, m_eof=0, valid one cycle after the sample. Frame end → token m_eof=1, m_data=1.
- Empty frame: no corners → exactly one token with m_data=0, m_eof=1. Corners with ce=0 produce nothing.
- Frame wrap: corners at (15,7), then (0,0) on the next ce → output order corner(15,7), token(count incl. it), corner(0,0). Next frame's token count=1.
- Backpressure (FIFO_DEPTH=8, m_ready=0, 10 corners in one frame):
  - 7 corners accepted, drop_cnt=3, overflow=1.
  - Token written as 8th entry with m_data=7; outputs stable until m_ready=1.
  - Then all 8 entries drain in order.
- clr_ovf:
  - After the backpressure case, clr_ovf=1 → overflow=0, drop_cnt=0.
  - clr_ovf coincident with a drop → overflow=1, drop_cnt=1.
- Reset mid-frame: assert rst=0 with 3 entries queued → m_valid=0 immediately (asynchronous), fifo_level=0. After release, the first token counts only post-reset corners.

Source files
------------

// File: rtl/corner_stream_collector.sv
// Collects post-NMS corner coordinates from the raster stream into a FIFO,
// closing each frame with an end-of-frame token that carries its corner count.
module corner_stream_collector #(
  parameter  int COL_NUM     = 640,
  parameter  int ROW_NUM     = 480,
  parameter  int COORD_WIDTH = 10,
  parameter  int FIFO_DEPTH  = 64,
  parameter  int DROP_WIDTH  = 16,
  localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     iscorner,
  input  logic [COORD_WIDTH-1:0]   x_coord,
  input  logic [COORD_WIDTH-1:0]   y_coord,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [2*COORD_WIDTH-1:0] m_data,
  output logic                     m_eof,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [DROP_WIDTH-1:0]    drop_cnt,
  output logic [LEVEL_W-1:0]       fifo_level
);

  localparam int DATA_W = 2 * COORD_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [COORD_WIDTH-1:0] LAST_X      = COORD_WIDTH'(COL_NUM - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_Y      = COORD_WIDTH'(ROW_NUM - 1);
  localparam logic [LEVEL_W-1:0]     FULL_LEVEL  = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0]     CORNER_MAX  = LEVEL_W'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic              eof;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Registered raster sample; all write decisions act on this stage.
  logic                   s_ce;
  logic                   s_corner;
  logic [COORD_WIDTH-1:0] s_x;
  logic [COORD_WIDTH-1:0] s_y;

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              token_pending;
  logic [DATA_W-1:0] frame_cnt;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic              wr_en;
  entry_t            wr_entry;
  logic              hold_load;
  logic              hold_clear;
  logic              drop;
  logic              token_pending_nxt;
  logic [DATA_W-1:0] frame_cnt_nxt;
  logic              corner_room;
  logic              token_room;
  logic              pop;
  logic              frame_end;
  logic [DATA_W-1:0] frame_cnt_inc;
  entry_t            rd_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ce     <= 1'b0;
      s_corner <= 1'b0;
      s_x      <= '0;
      s_y      <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      s_ce     <= ce;
      s_corner <= ce & iscorner;
      s_x      <= x_coord;
      s_y      <= y_coord;
    end
  end

  assign corner_room   = (fifo_level <= CORNER_MAX);
  assign token_room    = (fifo_level != FULL_LEVEL);
  assign frame_end     = s_ce && (s_x == LAST_X) && (s_y == LAST_Y);
  assign frame_cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + DATA_W'(1);

  // Single write port: pending token, then held corner, then new corner.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    wr_en             = 1'b0;
    wr_entry          = '0;
    hold_load         = 1'b0;
    hold_clear        = 1'b0;
    drop              = 1'b0;
    token_pending_nxt = token_pending;
    frame_cnt_nxt     = frame_cnt;

    if (token_pending) begin
      if (token_room) begin
        wr_en             = 1'b1;
        wr_entry          = '{eof: 1'b1, data: frame_cnt};
        token_pending_nxt = 1'b0;
        frame_cnt_nxt     = '0;
      end
      // Port stays reserved for the token; a new-frame corner waits or drops.
      if (s_corner) begin
        if (!hold_valid) hold_load = 1'b1;
        else             drop      = 1'b1;
      end
    end else if (hold_valid) begin
      hold_clear = 1'b1;
      if (corner_room) begin
        wr_en         = 1'b1;
        wr_entry      = '{eof: 1'b0, data: hold_data};
        frame_cnt_nxt = frame_cnt_inc;
      end else begin
        drop = 1'b1;
      end
      if (s_corner) hold_load = 1'b1;
    end else if (s_corner) begin
      if (corner_room) begin
        wr_en         = 1'b1;
        wr_entry      = '{eof: 1'b0, data: {s_y, s_x}};
        frame_cnt_nxt = frame_cnt_inc;
      end else begin
        drop = 1'b1;
      end
    end

    if (frame_end) token_pending_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      token_pending <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      token_pending <= token_pending_nxt;
      frame_cnt     <= frame_cnt_nxt;
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_data  <= {s_y, s_x};
      end else if (hold_clear) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // A drop in the same cycle as a clear leaves a fresh count of one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= DROP_WIDTH'(drop);
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_WIDTH'(1);
    end
  end

  assign pop = m_valid & m_ready;

  // NOTE: storage array is not reset; only pointers and level are, and the
  // output mux hides stale contents while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
        2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign rd_entry = mem[rd_ptr];
  assign m_valid  = (fifo_level != '0);
  assign m_data   = m_valid ? rd_entry.data : '0;
  assign m_eof    = m_valid ? rd_entry.eof  : 1'b0;

endmodule

// File: tb/tb_corner_stream_collector.sv
// Scoreboard bench for corner_stream_collector on a 16x8 frame with an 8-entry FIFO.
module tb_corner_stream_collector;

  localparam int CW = 10;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          iscorner;
  logic [CW-1:0] x_coord;
  logic [CW-1:0] y_coord;
  logic          m_valid;
  logic          m_ready;
  logic [2*CW-1:0] m_data;
  logic          m_eof;
  logic          overflow;
  logic          clr_ovf;
  logic [DW-1:0] drop_cnt;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad   = 0;
  logic [2*CW:0] exp_q[$];

  corner_stream_collector #(
    .COL_NUM(16), .ROW_NUM(8), .COORD_WIDTH(CW), .FIFO_DEPTH(8), .DROP_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner),
    .x_coord(x_coord), .y_coord(y_coord),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_eof(m_eof),
    .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*CW:0] corner_e(input int x, input int y);
    return {1'b0, CW'(y), CW'(x)};
  endfunction

  function automatic logic [2*CW:0] token_e(input int n);
    return {1'b1, (2*CW)'(n)};
  endfunction

  // Monitor: every accepted output beat is matched against the queue head.
  initial begin
    logic [2*CW:0] e;
    forever begin
      @(negedge clk);
      if (rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected: got %0h expected none", {m_eof, m_data});
        end else begin
          e = exp_q.pop_front();
          check("mon_entry", 32'({m_eof, m_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pix(input int x, input int y, input logic c);
    ce       = 1'b1;
    iscorner = c;
    x_coord  = CW'(x);
    y_coord  = CW'(y);
    @(posedge clk); #1;
    ce       = 1'b0;
    iscorner = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_valid) break;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; iscorner = 1'b0; x_coord = '0; y_coord = '0;
    m_ready = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_eof", 32'(m_eof), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic corner with latency check, then its frame token.
    x_coord = CW'(5); y_coord = CW'(7); ce = 1'b1; iscorner = 1'b1;
    exp_q.push_back(corner_e(5, 7));
    @(posedge clk); #1;
    ce = 1'b0; iscorner = 1'b0;
    check("lat_early", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(m_valid), 32'd1);
    check("lat_data", 32'(m_data), 32'h01C05);
    pix(15, 7, 1'b0);
    exp_q.push_back(token_e(1));
    wait_drain("basic");

    // Empty frame; corners and a final position with ce=0 are ignored.
    x_coord = CW'(4); y_coord = CW'(4); iscorner = 1'b1;
    @(posedge clk); #1;
    x_coord = CW'(15); y_coord = CW'(7);
    @(posedge clk); #1;
    iscorner = 1'b0;
    pix(15, 7, 1'b0);
    exp_q.push_back(token_e(0));
    wait_drain("empty");

    // Final-pixel corner, then an immediate next-frame corner.
    pix(15, 7, 1'b1);
    exp_q.push_back(corner_e(15, 7));
    exp_q.push_back(token_e(1));
    pix(0, 0, 1'b1);
    exp_q.push_back(corner_e(0, 0));
    pix(15, 7, 1'b0);
    exp_q.push_back(token_e(1));
    wait_drain("wrap");

    // Backpressure: 10 corners into 8 entries with one slot kept for the token.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix(i, 1, 1'b1);
      if (i < 7) exp_q.push_back(corner_e(i, 1));
    end
    pix(15, 7, 1'b0);
    exp_q.push_back(token_e(7));
    repeat (3) @(posedge clk);
    #1;
    check("bp_level", 32'(fifo_level), 32'd8);
    check("bp_drop", 32'(drop_cnt), 32'd3);
    check("bp_ovf", 32'(overflow), 32'd1);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_head", 32'({m_eof, m_data}), 32'h00400);
    repeat (3) @(posedge clk);
    #1;
    check("bp_stable", 32'({m_eof, m_data}), 32'h00400);
    m_ready = 1'b1;
    wait_drain("bp");

    // Overflow clear, then a clear coinciding with a drop.
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pix(i, 2, 1'b1);
      exp_q.push_back(corner_e(i, 2));
    end
    x_coord = CW'(7); y_coord = CW'(2); ce = 1'b1; iscorner = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0; iscorner = 1'b0; clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("clrdrop_ovf", 32'(overflow), 32'd1);
    check("clrdrop_cnt", 32'(drop_cnt), 32'd1);
    m_ready = 1'b1;
    wait_drain("clrdrop");

    // Asynchronous reset with entries queued mid-frame.
    m_ready = 1'b0;
    pix(1, 3, 1'b1);
    pix(2, 3, 1'b1);
    pix(3, 3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_data", 32'(m_data), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    pix(4, 4, 1'b1);
    exp_q.push_back(corner_e(4, 4));
    pix(15, 7, 1'b0);
    exp_q.push_back(token_e(1));
    wait_drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
